// File: rtl/dport_auxreq_pkg.sv
// Shared codes for the DisplayPort AUX request sequencer and its AUX engine.
// Latency: n/a (constants, types and a pure helper function).
// Backpressure: n/a.
package dport_auxreq_pkg;

    // AUX native command nibbles
    localparam logic [3:0] CMD_NATIVE_WR = 4'h8;
    localparam logic [3:0] CMD_NATIVE_RD = 4'h9;

    // Reply byte0[5:4]; any value with bit 5 set is a DEFER
    localparam logic [1:0] RPL_ACK  = 2'b00;
    localparam logic [1:0] RPL_NACK = 2'b01;

    // auxctrl / auxstat bit positions
    localparam int CTRL_GO_BIT   = 31;
    localparam int STAT_IDLE_BIT = 31;
    localparam int STAT_TMO_BIT  = 8;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_NACK  = 2'd1,
        ERR_RETRY = 2'd2,
        ERR_SHORT = 2'd3
    } err_t;

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_GO, S_SETTLE, S_WAIT,
        S_RDHDR, S_RDDATA, S_BACKOFF, S_FIN
    } state_t;

    // Transmit buffer byte k: 4-byte header followed by the write payload
    function automatic logic [7:0] tx_byte(input logic [3:0]  cmd,
                                           input logic [19:0] addr,
                                           input logic [1:0]  nb,
                                           input logic [31:0] wd,
                                           input logic [2:0]  k);
        case (k)
            3'd0:    tx_byte = {cmd, addr[19:16]};
            3'd1:    tx_byte = addr[15:8];
            3'd2:    tx_byte = addr[7:0];
            3'd3:    tx_byte = {6'b0, nb};
            default: tx_byte = wd[{k[1:0], 3'b000} +: 8];
        endcase
    endfunction

endpackage

// File: rtl/dport_auxreq_if.sv
// Request and AUX-engine buffer signals of the AUX request sequencer.
// Latency: n/a (wiring only).
// Backpressure: buffer accesses are req/ack; requests are gated by busy.
interface dport_auxreq_if;
    logic        start;
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [1:0]  nbytes;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [31:0] auxctrl;
    logic [31:0] auxstat;
    logic [4:0]  aux_addr;
    logic [31:0] aux_wdata;
    logic        aux_req;
    logic        aux_wr;
    logic        aux_ack;
    logic [31:0] aux_rdata;

    // Sequencer side
    modport slave (
        input  start, cmd, addr, nbytes, wdata, auxstat, aux_ack, aux_rdata,
        output busy, done, err, rdata, auxctrl, aux_addr, aux_wdata, aux_req, aux_wr
    );

    // Requester plus AUX engine side
    modport master (
        output start, cmd, addr, nbytes, wdata, auxstat, aux_ack, aux_rdata,
        input  busy, done, err, rdata, auxctrl, aux_addr, aux_wdata, aux_req, aux_wr
    );
endinterface

// File: rtl/dport_auxreq.sv
// Sequences one AUX native read/write: fill buffer, kick engine, parse reply, retry on defer/timeout.
// Latency: several cycles per buffer byte plus engine time; BACKOFF idle cycles between retries.
// Backpressure: start accepted only while busy=0; one buffer access outstanding, held until aux_ack.
module dport_auxreq
    import dport_auxreq_pkg::*;
#(
    parameter int RETRIES = 7,
    parameter int BACKOFF = 50000
) (
    input logic           clk,
    input logic           rstn,
    dport_auxreq_if.slave bus
);

    localparam int            BW      = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [BW-1:0] BO_LAST = BW'(BACKOFF - 1);
    localparam logic [3:0]    RT_MAX  = 4'(RETRIES);

    state_t        state;
    logic          sync_pend;   // engine may still be running a transaction we abandoned in reset
    logic          busy_q, done_q, aux_req_q, aux_wr_q;
    err_t          err_q;
    logic [31:0]   rdata_q, rbuf, auxctrl_q, aux_wdata_q;
    logic [4:0]    aux_addr_q, last_q, rlen_q;
    logic [3:0]    cmd_q, attempts;
    logic [19:0]   addr_q;
    logic [1:0]    nb_q;
    logic [31:0]   wdata_q;
    logic [2:0]    idx;
    logic [BW-1:0] bcnt;

    logic        aux_idle, aux_tmo, unused_bits;
    logic [31:0] go_word, rbuf_nx;
    logic [1:0]  ridx;
    logic [1:0]  rpl;

    assign aux_idle    = bus.auxstat[STAT_IDLE_BIT];
    assign aux_tmo     = bus.auxstat[STAT_TMO_BIT];
    assign unused_bits = ^{bus.auxstat[30:9], bus.auxstat[7:5], bus.aux_rdata[31:8]};
    assign go_word     = {1'b1, 26'b0, last_q};
    assign ridx        = idx[1:0] - 2'd1;
    assign rpl         = bus.aux_rdata[5:4];

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.auxctrl   = auxctrl_q;
    assign bus.aux_addr  = aux_addr_q;
    assign bus.aux_wdata = aux_wdata_q;
    assign bus.aux_req   = aux_req_q;
    assign bus.aux_wr    = aux_wr_q;

    // Read assembly buffer with the byte arriving on this ack merged in
    always_comb begin
        rbuf_nx = rbuf;
        rbuf_nx[{ridx, 3'b000} +: 8] = bus.aux_rdata[7:0];
    end

    // Request sequencer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            sync_pend   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= ERR_OK;
            rdata_q     <= '0;
            rbuf        <= '0;
            auxctrl_q   <= '0;
            aux_addr_q  <= '0;
            aux_wdata_q <= '0;
            aux_req_q   <= 1'b0;
            aux_wr_q    <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            nb_q        <= '0;
            wdata_q     <= '0;
            last_q      <= '0;
            rlen_q      <= '0;
            attempts    <= '0;
            idx         <= '0;
            bcnt        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sync_pend) begin
                        busy_q    <= !aux_idle;
                        sync_pend <= !aux_idle;
                    end else if (bus.start) begin
                        cmd_q    <= bus.cmd;
                        addr_q   <= bus.addr;
                        nb_q     <= bus.nbytes;
                        wdata_q  <= bus.wdata;
                        last_q   <= (bus.cmd == CMD_NATIVE_WR) ? 5'd4 + {3'b0, bus.nbytes} : 5'd3;
                        attempts <= '0;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (!aux_req_q) begin
                        aux_req_q   <= 1'b1;
                        aux_wr_q    <= 1'b1;
                        aux_addr_q  <= {2'b0, idx};
                        aux_wdata_q <= {24'b0, tx_byte(cmd_q, addr_q, nb_q, wdata_q, idx)} << {idx[1:0], 3'b000};
                    end else if (bus.aux_ack) begin
                        aux_req_q <= 1'b0;
                        aux_wr_q  <= 1'b0;
                        if (idx == last_q[2:0]) begin
                            auxctrl_q <= go_word;
                            attempts  <= attempts + 4'd1;
                            state     <= S_GO;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_GO: begin
                    auxctrl_q <= '0;
                    state     <= S_SETTLE;
                end
                S_SETTLE: state <= S_WAIT;
                S_WAIT: begin
                    if (aux_idle) begin
                        rlen_q <= bus.auxstat[4:0];
                        if (aux_tmo) begin
                            if (attempts == RT_MAX) begin
                                state <= S_FIN; done_q <= 1'b1; busy_q <= 1'b0; err_q <= ERR_RETRY;
                            end else begin
                                state <= S_BACKOFF; bcnt <= '0;
                            end
                        end else begin
                            idx   <= '0;
                            state <= S_RDHDR;
                        end
                    end
                end
                S_RDHDR: begin
                    if (!aux_req_q) begin
                        aux_req_q  <= 1'b1;
                        aux_wr_q   <= 1'b0;
                        aux_addr_q <= '0;
                    end else if (bus.aux_ack) begin
                        aux_req_q <= 1'b0;
                        if (rpl == RPL_NACK) begin
                            state <= S_FIN; done_q <= 1'b1; busy_q <= 1'b0; err_q <= ERR_NACK;
                        end else if (rpl[1]) begin
                            if (attempts == RT_MAX) begin
                                state <= S_FIN; done_q <= 1'b1; busy_q <= 1'b0; err_q <= ERR_RETRY;
                            end else begin
                                state <= S_BACKOFF; bcnt <= '0;
                            end
                        end else if (cmd_q == CMD_NATIVE_WR) begin
                            state <= S_FIN; done_q <= 1'b1; busy_q <= 1'b0; err_q <= ERR_OK;
                        end else if (rlen_q >= {3'b0, nb_q} + 5'd2) begin
                            rbuf  <= '0;
                            idx   <= 3'd1;
                            state <= S_RDDATA;
                        end else begin
                            state <= S_FIN; done_q <= 1'b1; busy_q <= 1'b0; err_q <= ERR_SHORT;
                        end
                    end
                end
                S_RDDATA: begin
                    if (!aux_req_q) begin
                        aux_req_q  <= 1'b1;
                        aux_wr_q   <= 1'b0;
                        aux_addr_q <= {2'b0, idx};
                    end else if (bus.aux_ack) begin
                        aux_req_q <= 1'b0;
                        rbuf      <= rbuf_nx;
                        if (idx == {1'b0, nb_q} + 3'd1) begin
                            rdata_q <= rbuf_nx;
                            state   <= S_FIN; done_q <= 1'b1; busy_q <= 1'b0; err_q <= ERR_OK;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_BACKOFF: begin
                    // buffer header is still intact, so a retry goes straight back to GO
                    if (bcnt == BO_LAST) begin
                        auxctrl_q <= go_word;
                        attempts  <= attempts + 4'd1;
                        state     <= S_GO;
                    end else begin
                        bcnt <= bcnt + BW'(1);
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dport_auxreq.sv
// Directed bench for dport_auxreq with a behavioural AUX engine (separate tx/rx buffers).
// Latency: n/a.
// Backpressure: engine acks each buffer access one cycle after aux_req.
module tb_dport_auxreq;

    localparam int BO    = 20;
    localparam int M_ACK = 0, M_NACK = 1, M_TMO = 2, M_HANG = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    dport_auxreq_if bus();

    dport_auxreq #(.RETRIES(7), .BACKOFF(BO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- AUX engine model ----------------
    logic [7:0]  tx_mem [32];
    logic [7:0]  rx_mem [32];
    logic [7:0]  rep [4];
    logic [4:0]  rlen_cfg = '0;
    int          mode = M_ACK;
    int          defer_until = 0;
    logic        rel_eng = 1'b0;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_idle = 1'b1;
    logic        m_tmo = 1'b0;
    logic [4:0]  m_rlen = '0;
    logic [4:0]  tx_last = '0;
    int          eng_cnt = 0;
    int          go_cnt = 0;
    int          cyc = 0;
    int          go_t [64];

    assign bus.aux_ack   = m_ack;
    assign bus.aux_rdata = m_rdata;
    assign bus.auxstat   = {m_idle, 22'd0, m_tmo, 3'd0, m_rlen};

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        m_ack <= bus.aux_req && !m_ack;
        if (bus.aux_req && !m_ack) begin
            if (bus.aux_wr) tx_mem[bus.aux_addr] <= bus.aux_wdata[{bus.aux_addr[1:0], 3'b000} +: 8];
            else            m_rdata <= {4{rx_mem[bus.aux_addr]}};
        end
        if (bus.auxctrl[31]) begin
            go_t[go_cnt] <= cyc;
            go_cnt       <= go_cnt + 1;
            tx_last      <= bus.auxctrl[4:0];
            m_idle       <= 1'b0;
            m_tmo        <= 1'b0;
            eng_cnt      <= 4;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && mode != M_HANG) begin
                m_idle <= 1'b1;
                if (mode == M_TMO) begin
                    m_tmo <= 1'b1;
                end else if (go_cnt <= defer_until) begin
                    rx_mem[0] <= 8'h20; m_rlen <= 5'd1;
                end else if (mode == M_NACK) begin
                    rx_mem[0] <= 8'h10; m_rlen <= 5'd1;
                end else begin
                    rx_mem[0] <= 8'h00;
                    for (int i = 0; i < 4; i++) rx_mem[i+1] <= rep[i];
                    m_rlen <= rlen_cfg;
                end
            end
        end else if (!m_idle && rel_eng) begin
            m_idle <= 1'b1;
        end
    end

    // ---------------- requester ----------------
    logic [1:0]  e;
    logic [31:0] rd;
    int          g0;

    // Issue one request from a negedge with busy=0 and wait (bounded) for done
    task automatic do_req(input logic [3:0] c, input logic [19:0] a, input logic [1:0] n,
                          input logic [31:0] wd, output logic [1:0] eo, output logic [31:0] ro);
        int k;
        bus.cmd = c; bus.addr = a; bus.nbytes = n; bus.wdata = wd; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_set", {31'b0, bus.busy}, 32'd1);
        k = 0;
        while (!bus.done && k < 5000) begin @(negedge clk); k++; end
        chk("done_seen", {31'b0, bus.done}, 32'd1);
        chk("busy_at_done", {31'b0, bus.busy}, 32'd0);
        eo = bus.err;
        ro = bus.rdata;
        @(negedge clk);
        chk("done_pulse", {31'b0, bus.done}, 32'd0);
    endtask

    initial begin
        int k;
        rstn = 1'b0;
        bus.start = 1'b0; bus.cmd = '0; bus.addr = '0; bus.nbytes = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_err", {30'b0, bus.err}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_auxctrl", bus.auxctrl, 32'd0);
        chk("rst_req", {30'b0, bus.aux_req, bus.aux_wr}, 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);

        // Native read, 4 bytes
        rep[0] = 8'h11; rep[1] = 8'h12; rep[2] = 8'h13; rep[3] = 8'h14; rlen_cfg = 5'd5;
        g0 = go_cnt;
        do_req(4'h9, 20'h00000, 2'd3, 32'h0, e, rd);
        chk("rd_hdr", {tx_mem[0], tx_mem[1], tx_mem[2], tx_mem[3]}, 32'h90000003);
        chk("rd_last", {27'b0, tx_last}, 32'd3);
        chk("rd_err", {30'b0, e}, 32'd0);
        chk("rd_data", rd, 32'h14131211);
        chk("rd_gos", go_cnt - g0, 32'd1);

        // Native write, 2 bytes
        g0 = go_cnt;
        do_req(4'h8, 20'h00100, 2'd1, 32'h00000A0B, e, rd);
        chk("wr_hdr", {tx_mem[0], tx_mem[1], tx_mem[2], tx_mem[3]}, 32'h80010001);
        chk("wr_pay", {16'b0, tx_mem[4], tx_mem[5]}, 32'h00000B0A);
        chk("wr_last", {27'b0, tx_last}, 32'd5);
        chk("wr_err", {30'b0, e}, 32'd0);
        chk("wr_rdata_hold", rd, 32'h14131211);

        // Two DEFERs then ACK
        rep[0] = 8'hA1; rep[1] = 8'hA2; rlen_cfg = 5'd3;
        g0 = go_cnt;
        defer_until = g0 + 2;
        do_req(4'h9, 20'h00200, 2'd1, 32'h0, e, rd);
        defer_until = 0;
        chk("df_gos", go_cnt - g0, 32'd3);
        chk("df_gap1", {31'b0, (go_t[g0+1] - go_t[g0]) >= BO}, 32'd1);
        chk("df_gap2", {31'b0, (go_t[g0+2] - go_t[g0+1]) >= BO}, 32'd1);
        chk("df_err", {30'b0, e}, 32'd0);
        chk("df_data", rd, 32'h0000A2A1);

        // Timeout on every attempt
        mode = M_TMO;
        g0 = go_cnt;
        do_req(4'h9, 20'h00300, 2'd0, 32'h0, e, rd);
        chk("to_gos", go_cnt - g0, 32'd7);
        chk("to_err", {30'b0, e}, 32'd2);
        chk("to_rdata_hold", rd, 32'h0000A2A1);

        // Short reply
        mode = M_ACK; rlen_cfg = 5'd3;
        g0 = go_cnt;
        do_req(4'h9, 20'h00000, 2'd3, 32'h0, e, rd);
        chk("sh_err", {30'b0, e}, 32'd3);
        chk("sh_gos", go_cnt - g0, 32'd1);
        chk("sh_rdata_hold", rd, 32'h0000A2A1);

        // NACK
        mode = M_NACK;
        g0 = go_cnt;
        do_req(4'h9, 20'h00000, 2'd0, 32'h0, e, rd);
        chk("nk_err", {30'b0, e}, 32'd1);
        chk("nk_gos", go_cnt - g0, 32'd1);

        // Reset while the engine is busy
        mode = M_HANG;
        g0 = go_cnt;
        bus.cmd = 4'h9; bus.addr = 20'h00010; bus.nbytes = 2'd0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (go_cnt == g0 && k < 200) begin @(negedge clk); k++; end
        chk("hg_go", {31'b0, go_cnt != g0}, 32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_busy", {31'b0, bus.busy}, 32'd0);
        chk("mr_auxctrl", bus.auxctrl, 32'd0);
        chk("mr_rdata", bus.rdata, 32'd0);
        chk("mr_req", {30'b0, bus.aux_req, bus.aux_wr}, 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_busy_sync", {31'b0, bus.busy}, 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_busy_hold", {31'b0, bus.busy}, 32'd1);
        rel_eng = 1'b1;
        k = 0;
        while (bus.busy && k < 100) begin @(negedge clk); k++; end
        rel_eng = 1'b0;
        chk("mr_busy_rel", {31'b0, bus.busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("mr_start_ignored", {31'b0, bus.busy}, 32'd0);
        mode = M_ACK; rep[0] = 8'h5A; rlen_cfg = 5'd2;
        do_req(4'h9, 20'h12345, 2'd0, 32'h0, e, rd);
        chk("mr_hdr", {tx_mem[0], tx_mem[1], tx_mem[2], tx_mem[3]}, 32'h91234500);
        chk("mr_err", {30'b0, e}, 32'd0);
        chk("mr_data", rd, 32'h0000005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
